// File: rtl/acc_mem_responder.sv
// Core-side cmem responder: takes one accelerator load/store at a time, runs it on the
// OBI-style data bus and returns exactly one response (data + error status) per request.
package acc_pkg;
  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_req_type_e;
endpackage

module acc_mem_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cmem_q_valid_i,
  output logic                        cmem_q_ready_o,
  input  acc_pkg::mem_req_type_e      cmem_q_req_type_i,
  input  logic [ADDR_WIDTH-1:0]       cmem_q_addr_i,
  input  logic [DATA_WIDTH-1:0]       cmem_q_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]     cmem_q_be_i,
  input  logic                        cmem_q_mode_i,
  input  logic                        cmem_q_spec_i,
  input  logic                        cmem_q_endoftransaction_i,
  output logic                        cmem_p_valid_o,
  input  logic                        cmem_p_ready_i,
  output logic [DATA_WIDTH-1:0]       cmem_p_rdata_o,
  output logic                        cmem_p_status_o,
  output logic                        cmem_p_last_o,
  output logic                        data_req_o,
  output logic                        data_we_o,
  output logic [ADDR_WIDTH-1:0]       data_addr_o,
  output logic [DATA_WIDTH/8-1:0]     data_be_o,
  output logic [DATA_WIDTH-1:0]       data_wdata_o,
  input  logic                        data_gnt_i,
  input  logic                        data_rvalid_i,
  input  logic                        data_err_i,
  input  logic [DATA_WIDTH-1:0]       data_rdata_i,
  output logic                        busy_o
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TMO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_LAST_INT[TMO_W-1:0];
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } state_e;

  state_e                   state_q;
  logic                     stale_q;
  logic [TMO_W-1:0]         tmo_q;
  logic [TMO_W-1:0]         tmo_d;
  logic                     we_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH/8-1:0]  be_q;
  logic                     eot_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     status_q;
  logic                     q_hs;
  logic                     tmo_hit;

  assign tmo_d   = tmo_q + 1'b1;
  assign q_hs    = cmem_q_valid_i && (state_q == IDLE) && !stale_q;
  assign tmo_hit = TMO_EN && (tmo_q == TMO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      stale_q  <= 1'b0;
      tmo_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      eot_q    <= 1'b0;
      rdata_q  <= '0;
      status_q <= 1'b0;
    end else begin
      // A late beat belonging to a timed-out access is dropped wherever it lands.
      if (stale_q && data_rvalid_i) begin
        stale_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (q_hs) begin
            we_q    <= (cmem_q_req_type_i == acc_pkg::WRITE);
            addr_q  <= cmem_q_addr_i;
            wdata_q <= cmem_q_wdata_i;
            be_q    <= cmem_q_be_i;
            eot_q   <= cmem_q_endoftransaction_i;
            if (cmem_q_mode_i || cmem_q_spec_i) begin
              rdata_q  <= '0;
              status_q <= 1'b1;
              state_q  <= RSP;
            end else begin
              state_q  <= REQ;
            end
          end
        end
        REQ: begin
          if (data_gnt_i) begin
            tmo_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (data_rvalid_i) begin
            rdata_q  <= we_q ? '0 : data_rdata_i;
            status_q <= data_err_i;
            state_q  <= RSP;
          end else if (tmo_hit) begin
            rdata_q  <= '0;
            status_q <= 1'b1;
            stale_q  <= 1'b1;
            state_q  <= RSP;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        RSP: begin
          if (cmem_p_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmem_q_ready_o  = (state_q == IDLE) && !stale_q;
  assign cmem_p_valid_o  = (state_q == RSP);
  assign cmem_p_rdata_o  = rdata_q;
  assign cmem_p_status_o = status_q;
  assign cmem_p_last_o   = eot_q;
  assign data_req_o      = (state_q == REQ);
  assign data_we_o       = we_q;
  assign data_addr_o     = addr_q;
  assign data_be_o       = be_q;
  assign data_wdata_o    = wdata_q;
  assign busy_o          = (state_q != IDLE) || stale_q;

endmodule

// File: doc/acc_mem_responder.md
# acc_mem_responder

Core-side responder for the accelerator memory (cmem) channel. Accepts one load/store request at a time from the FPU subsystem (or any accelerator issuing cmem requests), performs it on the core's OBI-style data bus, and returns exactly one cmem response (read data plus status) per accepted request. Sits between the cv-x-if accelerator adapter and the core LSU data port; one outstanding transaction; responds with an error status on unsupported, failed or timed-out requests.

## Interface
- ADDR_WIDTH, 32, address width of cmem request and data bus
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 wide
- TIMEOUT_CYCLES, 256, max cycles waiting for data_rvalid_i after grant; 0 disables timeout

Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cmem_q_valid_i  in  1  request valid
- cmem_q_ready_o  out  1  request ready
- cmem_q_req_type_i  in  acc_pkg::mem_req_type_e  READ or WRITE
- cmem_q_addr_i  in  ADDR_WIDTH  byte address
- cmem_q_wdata_i  in  DATA_WIDTH  store data
- cmem_q_be_i  in  DATA_WIDTH/8  byte enables
- cmem_q_mode_i  in  1  probe mode (unsupported)
- cmem_q_spec_i  in  1  speculative (unsupported)
- cmem_q_endoftransaction_i  in  1  last request of transaction
- cmem_p_valid_o  out  1  response valid
- cmem_p_ready_i  in  1  response ready
- cmem_p_rdata_o  out  DATA_WIDTH  load data (0 for writes/errors)
- cmem_p_status_o  out  1  1 = error
- cmem_p_last_o  out  1  echoes endoftransaction of the request
- data_req_o, data_we_o  out  1  bus request, write enable
- data_addr_o  out  ADDR_WIDTH; data_be_o  out  DATA_WIDTH/8; data_wdata_o  out  DATA_WIDTH
- data_gnt_i, data_rvalid_i, data_err_i  in  1  grant, response valid, bus error
- data_rdata_i  in  DATA_WIDTH  bus read data
- busy_o  out  1  state != IDLE or stale_q

## Operation
- FSM states IDLE, REQ, WAIT, RSP; plus flag stale_q and timeout counter tmo_q ($clog2(TIMEOUT_CYCLES+1) bits).
- IDLE: cmem_q_ready_o = ~stale_q. On request handshake latch type, addr, wdata, be, endoftransaction. If mode_i|spec_i: go RSP with status=1, rdata=0, no bus access. Else go REQ.
- REQ: data_req_o=1, data_we_o=(type==WRITE), bus fields from latched values, held stable until data_gnt_i. On gnt: go WAIT, tmo_q<=0. No timeout in REQ (request never withdrawn).
- WAIT: on data_rvalid_i: rdata = READ ? data_rdata_i : 0, status = data_err_i; go RSP. Else tmo_q++; when tmo_q reaches TIMEOUT_CYCLES-1 without rvalid: go RSP, status=1, rdata=0, set stale_q.
- RSP: cmem_p_valid_o=1, rdata/status/last stable until cmem_p_ready_i; then IDLE.
- stale_q: next data_rvalid_i is swallowed (no effect on response) and clears stale_q; new requests are not accepted while set.
- data_rvalid_i outside WAIT with stale_q=0 is ignored.

## Timing
- Reset: state IDLE, stale_q=0, tmo_q=0, all response/bus regs 0; outputs: cmem_q_ready_o=1, cmem_p_valid_o=0, data_req_o=0, busy_o=0. Reset mid-transaction abandons it; bus is reset with the block.
- Best-case latency: request handshake cycle 0, data_req_o cycle 1 (gnt in cycle 1), rvalid cycle 2, cmem_p_valid_o cycle 3. Unsupported request: cmem_p_valid_o cycle 1.
- cmem_q_ready_o only in IDLE: no new request accepted in the RSP handshake cycle; back-to-back requests spaced ≥4 cycles.
- Outputs are registered state decodes; no combinational path from cmem_q_valid_i to data_req_o.
- Timeout fires exactly TIMEOUT_CYCLES cycles after entering WAIT; rvalid in that same cycle wins (normal response, no stale).

## Test plan
- READ addr 0x100, gnt cycle 1, rvalid cycle 2 with rdata 0xDEADBEEF -> cmem_p_valid_o cycle 3, rdata 0xDEADBEEF, status 0.
- WRITE addr 0x204, wdata 0x12345678, be 0xF, gnt delayed 3 cycles -> data_req_o/addr/wdata stable 4 cycles, response rdata 0, status 0.
- READ with data_err_i=1 on rvalid -> status 1; cmem_p_ready_i low 5 cycles -> response held stable, then IDLE, ready=1.
- cmem_q_spec_i=1 -> no data_req_o, response cycle 1 with status 1; last echoes endoftransaction=1.
- TIMEOUT_CYCLES=4, gnt but no rvalid -> status 1 response after 4 WAIT cycles; cmem_q_ready_o=0 until late rvalid arrives, which is swallowed; next READ completes normally.
- rst_i asserted in WAIT -> next cycle IDLE, cmem_q_ready_o=1, cmem_p_valid_o=0, busy_o=0.
